// File: rtl/password_link_serializer.sv
// password_link_serializer: masks a credential word with a session key and streams it MSB byte first over valid/ready.
// Optional CRC-8 trailer byte when CRC8_TRAILER_EN is defined.
module password_link_serializer #(
  parameter int DATA_BYTES = 16
`ifdef CRC8_TRAILER_EN
  ,
  parameter logic [7:0] CRC_POLY = 8'h07,
  parameter logic [7:0] CRC_INIT = 8'h00
`endif
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [8*DATA_BYTES-1:0] in_data,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [8*DATA_BYTES-1:0] key,
  input  logic                    key_valid,
  output logic [7:0]              out_byte,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    out_last,
  output logic                    busy,
  output logic                    err_nokey
);
  localparam int W  = 8*DATA_BYTES;
  localparam int CW = $clog2(DATA_BYTES+1);
`ifdef CRC8_TRAILER_EN
  typedef enum logic [1:0] {IDLE, SEND, TRAIL} state_t;
`else
  typedef enum logic [1:0] {IDLE, SEND} state_t;
`endif
  state_t state_q, state_d;
  logic [W-1:0]  data_q, data_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          err_q, err_d;
  logic          idle, last_data;
`ifdef CRC8_TRAILER_EN
  logic [7:0] crc_q, crc_d;
  function automatic logic [7:0] crc8(input logic [7:0] c, input logic [7:0] b);
    logic [7:0] r;
    r = c ^ b;
    for (int i = 0; i < 8; i++) r = r[7] ? ((r << 1) ^ CRC_POLY) : (r << 1);
    return r;
  endfunction
`endif
  assign idle      = state_q == IDLE;
  assign last_data = cnt_q == CW'(DATA_BYTES-1);
  assign in_ready  = idle && key_valid;
  assign out_valid = !idle;
  assign busy      = !idle;
  assign err_nokey = err_q;
`ifdef CRC8_TRAILER_EN
  assign out_byte  = (state_q == TRAIL) ? crc_q : data_q[W-1 -: 8];
  assign out_last  = state_q == TRAIL;
`else
  assign out_byte  = data_q[W-1 -: 8];
  assign out_last  = (state_q == SEND) && last_data;
`endif
  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    cnt_d   = cnt_q;
`ifdef CRC8_TRAILER_EN
    crc_d   = crc_q;
`endif
    err_d   = idle && in_valid && !key_valid;
    if (in_valid && in_ready) begin
      data_d  = in_data ^ key;
      cnt_d   = '0;
      state_d = SEND;
`ifdef CRC8_TRAILER_EN
      crc_d   = CRC_INIT;
`endif
    end else if (state_q == SEND && out_ready) begin
      data_d = data_q << 8;
      cnt_d  = cnt_q + CW'(1);
`ifdef CRC8_TRAILER_EN
      crc_d  = crc8(crc_q, out_byte);
`endif
      if (last_data) begin
        data_d = '0;
        cnt_d  = '0;
`ifdef CRC8_TRAILER_EN
        state_d = TRAIL;
`else
        state_d = IDLE;
`endif
      end
    end
`ifdef CRC8_TRAILER_EN
    else if (state_q == TRAIL && out_ready) begin
      state_d = IDLE;
      crc_d   = CRC_INIT;
    end
`endif
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      data_q  <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
`ifdef CRC8_TRAILER_EN
      crc_q   <= CRC_INIT;
`endif
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
`ifdef CRC8_TRAILER_EN
      crc_q   <= crc_d;
`endif
    end
  end
endmodule

// File: tb/tb_password_link_serializer.sv
// tb_password_link_serializer: table vectors, corner sequences and random frames against a byte-queue reference model.
module tb_password_link_serializer;
  logic         clk = 1'b0;
  logic         reset_n;
  logic [127:0] in_data, key;
  logic         in_valid, key_valid, out_ready;
  logic         in_ready, out_valid, out_last, busy, err_nokey;
  logic [7:0]   out_byte;
  int           total = 0, passed = 0;

  password_link_serializer dut (
    .clk(clk), .reset_n(reset_n), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .key(key), .key_valid(key_valid), .out_byte(out_byte), .out_valid(out_valid),
    .out_ready(out_ready), .out_last(out_last), .busy(busy), .err_nokey(err_nokey)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [127:0] d;
    logic [127:0] k;
    int           mode;
    logic [7:0]   first;
    logic [7:0]   last;
  } vec_t;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

`ifdef CRC8_TRAILER_EN
  // Bit-serial long division of the whole masked message.
  function automatic logic [7:0] crc_model(input logic [7:0] q[$]);
    logic [7:0] c = 8'h00;
    logic       fb;
    foreach (q[i]) for (int b = 7; b >= 0; b--) begin
      fb = c[7] ^ q[i][b];
      c  = {c[6:0], 1'b0};
      if (fb) c = c ^ 8'h07;
    end
    return c;
  endfunction
`endif

  // mode 0: always ready, 1: random backpressure, 2: five-cycle stall on byte index 3
  task automatic run_frame(input logic [127:0] d, input logic [127:0] k, input int mode,
                           output logic [7:0] fb, output logic [7:0] lb);
    logic [7:0]   q[$];
    logic [127:0] m;
    logic         r;
    int           idx = 0, budget = 0, st = 0;
    m = d ^ k;
    for (int i = 0; i < 16; i++) q.push_back(m[127-8*i -: 8]);
`ifdef CRC8_TRAILER_EN
    q.push_back(crc_model(q));
`endif
    fb = 8'h00;
    lb = 8'h00;
    in_data = d; key = k; key_valid = 1'b1; in_valid = 1'b1;
    #1;
    chk("in_ready_idle", in_ready, 1);
    tick();
    in_valid  = 1'b0;
    key       = {$urandom, $urandom, $urandom, $urandom};
    key_valid = 1'($urandom % 2);
    while (idx < q.size() && budget < 400) begin
      chk("out_valid", out_valid, 1);
      chk("busy", busy, 1);
      chk("out_byte", out_byte, q[idx]);
      chk("out_last", out_last, 128'(idx == q.size() - 1));
      chk("in_ready_busy", in_ready, 0);
      chk("err_nokey_busy", err_nokey, 0);
      if (idx == 0) fb = out_byte;
      lb = out_byte;
      r = (mode == 0) ? 1'b1 : (mode == 1) ? ($urandom % 3 != 0) : !(idx == 3 && st < 5);
      if (!r) st++;
      in_valid  = (r && idx == q.size() - 1) ? 1'b0 : 1'($urandom % 2);
      out_ready = r;
      tick();
      if (r) idx++;
      budget++;
    end
    chk("frame_len", idx, q.size());
    in_valid = 1'b0;
    #1;
    chk("end_out_valid", out_valid, 0);
    chk("end_busy", busy, 0);
    chk("end_out_last", out_last, 0);
    chk("end_buffer", dut.data_q, 0);
    chk("end_in_ready", in_ready, key_valid);
    if (mode == 2) chk("stall_len", st, 5);
  endtask

  initial begin
    vec_t       tab[3];
    logic [7:0] fb, lb;
    logic [127:0] d0;
    d0 = 128'h00112233445566778899AABBCCDDEEFF;
    tab[0] = '{d0, 128'h0,   0, 8'h00, 8'hFF};
    tab[1] = '{d0, '1,       0, 8'hFF, 8'h00};
    tab[2] = '{d0, 128'h0,   2, 8'h00, 8'hFF};

    reset_n = 1'b0; in_data = '0; key = '0; in_valid = 1'b0; key_valid = 1'b0; out_ready = 1'b0;
    repeat (2) tick();
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_byte", out_byte, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_last", out_last, 0);
    chk("rst_busy", busy, 0);
    chk("rst_err_nokey", err_nokey, 0);
    reset_n = 1'b1;
    tick();

    foreach (tab[i]) begin
      run_frame(tab[i].d, tab[i].k, tab[i].mode, fb, lb);
      chk("vec_first", fb, tab[i].first);
`ifndef CRC8_TRAILER_EN
      chk("vec_last", lb, tab[i].last);
`endif
    end

    key_valid = 1'b0; in_valid = 1'b1; in_data = d0;
    #1;
    chk("nokey_in_ready", in_ready, 0);
    chk("nokey_err_pre", err_nokey, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("nokey_err", err_nokey, 1);
      chk("nokey_out_valid", out_valid, 0);
    end
    in_valid = 1'b0;
    tick();
    chk("nokey_err_post", err_nokey, 0);
    chk("nokey_busy", busy, 0);

    in_data = d0; key = '0; key_valid = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    repeat (4) tick();
    chk("pre_rst_byte", out_byte, 8'h44);
    reset_n = 1'b0;
    #1;
    chk("abort_out_valid", out_valid, 0);
    chk("abort_busy", busy, 0);
    chk("abort_out_byte", out_byte, 0);
    chk("abort_buffer", dut.data_q, 0);
    tick();
    reset_n = 1'b1;
    tick();
    run_frame(128'hA5A5_0F0F_1234_5678_9ABC_DEF0_0102_0304, 128'h0, 0, fb, lb);
    chk("restart_first", fb, 8'hA5);

    for (int i = 0; i < 6; i++)
      run_frame({$urandom, $urandom, $urandom, $urandom}, {$urandom, $urandom, $urandom, $urandom}, 1, fb, lb);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
